// File: rtl/online_pkg.sv
// Shared definitions for the radix-2 signed-digit online datapath:
// digit codes, controller state encoding and the digit decode helper.
package online_pkg;

    // Signed-digit codes: [1] = plus, [0] = minus. Code 2'b11 decodes as zero.
    localparam logic [1:0] SD_POS  = 2'b10;
    localparam logic [1:0] SD_NEG  = 2'b01;
    localparam logic [1:0] SD_ZERO = 2'b00;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    // Map a digit code onto its signed value (+1, -1 or 0).
    function automatic logic signed [1:0] sd_decode(input logic [1:0] code);
        logic signed [1:0] val;
        case (code)
            SD_POS:  val = 2'sb01;
            SD_NEG:  val = 2'sb11;
            default: val = 2'sb00;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/online_mult_seq_ca_reg.sv
// sd_ca_reg: on-the-fly conversion of an MSD-first signed-digit stream into
// a two's-complement fixed-point value (3 integer bits, F fraction bits).
// Q holds the value so far and QM = Q - 2^-t, so appending a digit of weight
// 2^-(t+1) only ever ORs a single bit into one of them: no carry chain.
// LOOKAHEAD selects whether 'value' shows the stored Q or the value that
// includes the digit presented this cycle.
module sd_ca_reg
    import online_pkg::*;
#(
    parameter int N         = 16,
    parameter int F         = 20,
    parameter int CNT_W     = 6,
    parameter bit LOOKAHEAD = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [CNT_W-1:0] t_idx,
    input  logic [1:0]       digit,
    output logic [F+2:0]     value
);

    localparam int W = F + 3;
    localparam logic [W-1:0] MINUS_ONE = {3'b111, {F{1'b0}}};

    logic [W-1:0] q_r;
    logic [W-1:0] qm_r;
    logic [W-1:0] bit_s;
    logic [W-1:0] q_nxt_s;
    logic [W-1:0] qm_nxt_s;

    // Weight bit 2^-(t+1) and the Q/QM update for the presented digit.
    always_comb begin
        bit_s = {W{1'b0}};
        for (int i = 0; i < F; i++) begin
            bit_s[i] = (int'(t_idx) == (F - 1 - i)) && (int'(t_idx) < N);
        end
        if (en) begin
            case (digit)
                SD_POS: begin
                    q_nxt_s  = q_r | bit_s;
                    qm_nxt_s = q_r;
                end
                SD_NEG: begin
                    q_nxt_s  = qm_r | bit_s;
                    qm_nxt_s = qm_r;
                end
                default: begin
                    q_nxt_s  = q_r;
                    qm_nxt_s = qm_r | bit_s;
                end
            endcase
        end else begin
            q_nxt_s  = q_r;
            qm_nxt_s = qm_r;
        end
    end

    // Q/QM storage; clear restarts the stream at t = 0 (Q = 0, QM = -1).
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            q_r  <= {W{1'b0}};
            qm_r <= MINUS_ONE;
        end else if (en) begin
            q_r  <= q_nxt_s;
            qm_r <= qm_nxt_s;
        end
    end

    assign value = LOOKAHEAD ? q_nxt_s : q_r;

endmodule

// File: rtl/online_mult_seq.sv
// online_mult_seq: handshaked radix-2 signed-digit online multiplier.
// Takes two MSD-first digit streams of N digits and emits N product digits,
// the first one DELTA accepted digits late. After the last input digit the
// block flushes DELTA steps with zero inputs to drain the residual w.
module online_mult_seq
    import online_pkg::*;
#(
    parameter int N     = 16,
    parameter int DELTA = 3,
    parameter int CNT_W = 6
) (
    input  logic       clk,
    input  logic       asyn_reset,
    input  logic       start,
    input  logic [1:0] x_value,
    input  logic [1:0] y_value,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [1:0] p_value,
    output logic       out_valid,
    output logic       done,
    output logic       busy
);

    localparam int F = N + DELTA + 1;
    localparam int W = F + 3;

    localparam logic signed [W-1:0] ONE_C      = {{(W-1){1'b0}}, 1'b1} << F;
    localparam logic signed [W-1:0] HALF_C     = {{(W-1){1'b0}}, 1'b1} << (F - 1);
    localparam logic signed [W-1:0] NEG_HALF_C = -HALF_C;

    localparam logic [CNT_W-1:0] T_ONE      = CNT_W'(1);
    localparam logic [CNT_W-1:0] T_DELTA    = CNT_W'(DELTA);
    localparam logic [CNT_W-1:0] T_LAST_RUN = CNT_W'(N - 1);
    localparam logic [CNT_W-1:0] T_LAST     = CNT_W'(N + DELTA - 1);

    state_t               state_r;
    logic [CNT_W-1:0]     t_r;
    logic signed [W-1:0]  w_r;
    logic [1:0]           p_value_r;
    logic                 out_valid_r;
    logic                 done_r;
    logic                 busy_r;
    logic                 in_ready_r;

    logic                 run_step_s;
    logic                 clr_s;
    logic                 sel_s;
    logic signed [1:0]    x_d_s;
    logic signed [1:0]    y_d_s;
    logic signed [W-1:0]  x_cur_s;
    logic signed [W-1:0]  y_nxt_s;
    logic signed [W-1:0]  tx_s;
    logic signed [W-1:0]  ty_s;
    logic signed [W-1:0]  v_s;
    logic signed [W-1:0]  w_nxt_s;
    logic [1:0]           p_code_s;

    // X is used before this step's digit is added, Y after it.
    sd_ca_reg #(.N(N), .F(F), .CNT_W(CNT_W), .LOOKAHEAD(1'b0)) u_x_reg (
        .clk   (clk),
        .rst   (asyn_reset),
        .clr   (clr_s),
        .en    (run_step_s),
        .t_idx (t_r),
        .digit (x_value),
        .value (x_cur_s)
    );

    sd_ca_reg #(.N(N), .F(F), .CNT_W(CNT_W), .LOOKAHEAD(1'b1)) u_y_reg (
        .clk   (clk),
        .rst   (asyn_reset),
        .clr   (clr_s),
        .en    (run_step_s),
        .t_idx (t_r),
        .digit (y_value),
        .value (y_nxt_s)
    );

    // Residual recurrence v = 2w + (x*Y' + y*X)*2^-DELTA and digit selection.
    always_comb begin
        run_step_s = (state_r == ST_RUN) && in_valid;
        clr_s      = (state_r == ST_IDLE) && start && !done_r;
        sel_s      = (t_r >= T_DELTA);
        if (run_step_s) begin
            x_d_s = sd_decode(x_value);
            y_d_s = sd_decode(y_value);
        end else begin
            x_d_s = 2'sb00;
            y_d_s = 2'sb00;
        end
        case (x_d_s)
            2'sb01:  tx_s = y_nxt_s >>> DELTA;
            2'sb11:  tx_s = -(y_nxt_s >>> DELTA);
            default: tx_s = {W{1'b0}};
        endcase
        case (y_d_s)
            2'sb01:  ty_s = x_cur_s >>> DELTA;
            2'sb11:  ty_s = -(x_cur_s >>> DELTA);
            default: ty_s = {W{1'b0}};
        endcase
        v_s = (w_r <<< 1) + tx_s + ty_s;
        if (!sel_s) begin
            p_code_s = SD_ZERO;
            w_nxt_s  = v_s;
        end else if (v_s >= HALF_C) begin
            p_code_s = SD_POS;
            w_nxt_s  = v_s - ONE_C;
        end else if (v_s < NEG_HALF_C) begin
            p_code_s = SD_NEG;
            w_nxt_s  = v_s + ONE_C;
        end else begin
            p_code_s = SD_ZERO;
            w_nxt_s  = v_s;
        end
    end

    // Controller: IDLE -> RUN (N accepted digits) -> FLUSH (DELTA steps) -> IDLE.
    always_ff @(posedge clk) begin
        if (asyn_reset) begin
            state_r     <= ST_IDLE;
            t_r         <= {CNT_W{1'b0}};
            w_r         <= {W{1'b0}};
            p_value_r   <= SD_ZERO;
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            busy_r      <= 1'b0;
            in_ready_r  <= 1'b0;
        end else begin
            out_valid_r <= 1'b0;
            done_r      <= 1'b0;
            p_value_r   <= SD_ZERO;
            case (state_r)
                ST_IDLE: begin
                    in_ready_r <= 1'b0;
                    // done_r marks the done cycle, where a start is ignored.
                    if (start && !done_r) begin
                        state_r    <= ST_RUN;
                        t_r        <= {CNT_W{1'b0}};
                        w_r        <= {W{1'b0}};
                        busy_r     <= 1'b1;
                        in_ready_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (in_valid) begin
                        t_r         <= t_r + T_ONE;
                        w_r         <= w_nxt_s;
                        out_valid_r <= sel_s;
                        p_value_r   <= p_code_s;
                        if (t_r == T_LAST_RUN) begin
                            state_r    <= ST_FLUSH;
                            in_ready_r <= 1'b0;
                        end
                    end
                end
                ST_FLUSH: begin
                    t_r         <= t_r + T_ONE;
                    w_r         <= w_nxt_s;
                    out_valid_r <= sel_s;
                    p_value_r   <= p_code_s;
                    if (t_r == T_LAST) begin
                        state_r <= ST_IDLE;
                        done_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_IDLE;
                    busy_r     <= 1'b0;
                    in_ready_r <= 1'b0;
                end
            endcase
        end
    end

    assign p_value   = p_value_r;
    assign out_valid = out_valid_r;
    assign done      = done_r;
    assign busy      = busy_r;
    assign in_ready  = in_ready_r;

endmodule

// File: tb/tb_online_mult_seq.sv
// Directed bench for online_mult_seq with N=8, DELTA=3.
// Product digits are collected by a negedge monitor and compared with
// hand-derived digit strings, values and pulse timing.
module tb_online_mult_seq;
    import online_pkg::*;

    localparam int N     = 8;
    localparam int DELTA = 3;
    localparam int CNT_W = 6;
    // Residual format: 12 fraction bits, 15 bits total; +-1.0 bounds.
    localparam logic signed [14:0] W_ONE     = 15'sd4096;
    localparam logic signed [14:0] W_NEG_ONE = -15'sd4096;

    logic       clk = 1'b0;
    logic       asyn_reset;
    logic       start;
    logic [1:0] x_value;
    logic [1:0] y_value;
    logic       in_valid;
    logic       in_ready;
    logic [1:0] p_value;
    logic       out_valid;
    logic       done;
    logic       busy;

    online_mult_seq #(.N(N), .DELTA(DELTA), .CNT_W(CNT_W)) dut (
        .clk        (clk),
        .asyn_reset (asyn_reset),
        .start      (start),
        .x_value    (x_value),
        .y_value    (y_value),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .p_value    (p_value),
        .out_valid  (out_valid),
        .done       (done),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int n_to  = 0;

    // Cycle counter used for pulse timing.
    always @(posedge clk) cyc <= cyc + 1;

    logic [1:0] pdig  [0:255];
    int         pcyc  [0:255];
    logic       pdone [0:255];
    int   n_pulse  = 0;
    int   n_code11 = 0;
    int   n_orphan = 0;
    int   n_wbig   = 0;
    logic acc_last = 1'b0;
    logic in_stream = 1'b0;

    // Output monitor: records every product digit and flags illegal behaviour.
    always @(negedge clk) begin
        if (out_valid) begin
            if (n_pulse < 256) begin
                pdig[n_pulse]  = p_value;
                pcyc[n_pulse]  = cyc;
                pdone[n_pulse] = done;
            end
            if (in_stream && !acc_last) n_orphan++;
            n_pulse++;
        end
        if (p_value == 2'b11) n_code11++;
        if (dut.w_r > W_ONE || dut.w_r < W_NEG_ONE) n_wbig++;
        acc_last = in_valid && in_ready;
    end

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One complete operation; digit i of xs/ys sits in bits [15-2i -: 2].
    task automatic run_op(input logic [15:0] xs, input logic [15:0] ys, input int gap,
                          input bit start_mid, input bit start_done,
                          output int c0, output int base);
        int g;
        @(posedge clk); #1;
        base  = n_pulse;
        start = 1'b1;
        c0    = cyc;
        @(posedge clk); #1;
        start     = 1'b0;
        in_stream = 1'b1;
        for (int i = 0; i < N; i++) begin
            x_value  = xs[15-2*i -: 2];
            y_value  = ys[15-2*i -: 2];
            in_valid = 1'b1;
            start    = start_mid && (i == 2);
            g = 0;
            while (!in_ready && g < 20) begin
                @(posedge clk); #1;
                g++;
            end
            if (g >= 20) n_to++;
            @(posedge clk); #1;
            start    = 1'b0;
            in_valid = 1'b0;
            x_value  = SD_POS;
            y_value  = SD_NEG;
            if (i < N - 1) begin
                repeat (gap) begin
                    @(posedge clk); #1;
                end
            end
        end
        in_stream = 1'b0;
        g = 0;
        while (!done && g < 40) begin
            @(posedge clk); #1;
            g++;
        end
        chk("done_seen", int'(done), 1);
        chk("busy_at_done", int'(busy), 1);
        start = start_done;
        @(posedge clk); #1;
        start = 1'b0;
        chk("busy_after_done", int'(busy), 0);
    endtask

    // exact16 is x*y in units of 2^-16; the digit value is in units of 2^-8.
    task automatic check_op(input string tag, input int base, input int c0, input int gap,
                            input logic [15:0] exp_vec, input int exp_val, input int exact16);
        logic [15:0] vec;
        int val;
        int err;
        vec = 16'h0000;
        val = 0;
        chk({tag, "_count"}, n_pulse - base, N);
        for (int i = 0; i < N; i++) begin
            vec = {vec[13:0], pdig[base+i]};
            if (pdig[base+i] == SD_POS) val += (1 << (N - 1 - i));
            else if (pdig[base+i] == SD_NEG) val -= (1 << (N - 1 - i));
        end
        chk({tag, "_digits"}, int'(vec), int'(exp_vec));
        chk({tag, "_value"}, val, exp_val);
        err = val * 256 - exact16;
        if (err < 0) err = -err;
        chk({tag, "_within_ulp"}, int'(err <= 256), 1);
        // First pulse follows the 4th accepted digit, last follows flush step 3.
        chk({tag, "_first_cyc"}, pcyc[base] - c0, 5 + 3 * gap);
        chk({tag, "_last_cyc"}, pcyc[base+N-1] - c0, 12 + 7 * gap);
        chk({tag, "_done_on_last"}, int'(pdone[base+N-1]), 1);
        chk({tag, "_no_early_done"}, int'(pdone[base+N-2]), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    int c0;
    int base;

    initial begin
        asyn_reset = 1'b1;
        start      = 1'b1;
        in_valid   = 1'b0;
        x_value    = SD_ZERO;
        y_value    = SD_ZERO;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs", int'({p_value, out_valid, done, busy, in_ready}), 0);
        asyn_reset = 1'b0;
        start      = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", int'({busy, in_ready}), 0);

        // 0.5 x 0.5: digits +1,-1,0.. = 0.25
        run_op(16'h8000, 16'h8000, 0, 1'b0, 1'b0, c0, base);
        check_op("half_x_half", base, c0, 0, 16'h9000, 64, 16384);

        // -0.75 x 0.5: digits -1,+1,-1,0.. = -0.375
        run_op(16'h5000, 16'h8000, 0, 1'b0, 1'b0, c0, base);
        check_op("neg_x_half", base, c0, 0, 16'h6400, -96, -24576);

        // (255/256)^2: seven +1 digits then 0 = 254/256
        run_op(16'hAAAA, 16'hAAAA, 0, 1'b0, 1'b0, c0, base);
        check_op("max_x_max", base, c0, 0, 16'hAAA8, 254, 65025);

        // Same as the first case with 3 stall cycles between digits
        run_op(16'h8000, 16'h8000, 3, 1'b0, 1'b0, c0, base);
        check_op("stalled", base, c0, 3, 16'h9000, 64, 16384);

        // start while running and in the done cycle must both be ignored
        run_op(16'h8000, 16'h8000, 0, 1'b1, 1'b1, c0, base);
        check_op("start_ignored", base, c0, 0, 16'h9000, 64, 16384);
        repeat (10) begin
            @(posedge clk); #1;
        end
        chk("no_phantom_op", n_pulse - base, N);

        // Reset after 4 accepted digits aborts the operation
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        in_valid = 1'b1;
        x_value  = SD_POS;
        y_value  = SD_POS;
        repeat (4) begin
            @(posedge clk); #1;
            x_value = SD_ZERO;
            y_value = SD_ZERO;
        end
        asyn_reset = 1'b1;
        in_valid   = 1'b0;
        @(posedge clk); #1;
        chk("abort_outputs", int'({p_value, out_valid, done, busy, in_ready}), 0);
        asyn_reset = 1'b0;
        base = n_pulse;
        repeat (20) begin
            @(posedge clk); #1;
        end
        chk("abort_no_output", n_pulse - base, 0);

        run_op(16'h8000, 16'h8000, 0, 1'b0, 1'b0, c0, base);
        check_op("after_abort", base, c0, 0, 16'h9000, 64, 16384);

        chk("no_code_11", n_code11, 0);
        chk("no_stall_pulse", n_orphan, 0);
        chk("residual_bound", n_wbig, 0);
        chk("ready_timeouts", n_to, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
